// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle datapath.
// Sequences fetch/decode/execute/memory/writeback and counts retires.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  Operation,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_source,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    IMMEX    = 4'd9,
    IMMWB    = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t     cur;
  logic [5:0] op_q;
  logic       retiring;
  logic       pc_write, pc_write_cond;
  logic       mr_raw, mw_raw, irw_raw, rw_raw, ill_raw;

  assign state = cur;

  // Retire is taken on the edge that leaves a final instruction state.
  always_comb begin
    retiring = 1'b0;
    case (cur)
      MEMWB, ALUWB, BRANCH, IMMWB, JUMP: retiring = 1'b1;
      MEMWRITE: retiring = mem_ready;
      default: retiring = 1'b0;
    endcase
  end

  // State register, opcode latch and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= FETCH;
      op_q    <= 6'd0;
      retired <= 32'd0;
    end else begin
      if (retiring)
        retired <= retired + 32'd1;
      if (cur == DECODE)
        op_q <= opcode;
      case (cur)
        FETCH:
          if (mem_ready) cur <= DECODE;
        DECODE:
          unique case (1'b1)
            opcode == OP_R:
              cur <= EXECUTE;
            opcode == OP_LW || opcode == OP_SW:
              cur <= MEMADR;
            opcode == OP_BEQ:
              cur <= BRANCH;
            opcode == OP_ADDI || opcode == OP_ANDI:
              cur <= IMMEX;
            opcode == OP_J:
              cur <= JUMP;
            default:
              cur <= FETCH;
          endcase
        MEMADR:
          cur <= (op_q == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:
          if (mem_ready) cur <= MEMWB;
        MEMWRITE:
          if (mem_ready) cur <= FETCH;
        EXECUTE: cur <= ALUWB;
        IMMEX:   cur <= IMMWB;
        default: cur <= FETCH;
      endcase
    end
  end

  // Moore decode of datapath controls; fetch strobes wait on memory.
  always_comb begin
    Operation     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    iord          = 1'b0;
    mr_raw        = 1'b0;
    mw_raw        = 1'b0;
    irw_raw       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    rw_raw        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    ill_raw       = 1'b0;
    case (cur)
      FETCH: begin
        mr_raw    = 1'b1;
        alu_src_b = 2'b01;
        irw_raw   = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ill_raw   = !(opcode == OP_R || opcode == OP_LW ||
                      opcode == OP_SW || opcode == OP_BEQ ||
                      opcode == OP_ADDI || opcode == OP_ANDI ||
                      opcode == OP_J);
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEMREAD: begin
        mr_raw = 1'b1;
        iord   = 1'b1;
      end
      MEMWB: begin
        rw_raw     = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWRITE: begin
        mw_raw = 1'b1;
        iord   = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        Operation = 2'b10;
      end
      ALUWB: begin
        rw_raw  = 1'b1;
        reg_dst = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        Operation     = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        Operation = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
      end
      IMMWB: rw_raw = 1'b1;
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign mem_read   = mr_raw & ~reset;
  assign mem_write  = mw_raw & ~reset;
  assign ir_write   = irw_raw & ~reset;
  assign reg_write  = rw_raw & ~reset;
  assign illegal_op = ill_raw & ~reset;
  assign pc_en      = (pc_write | (pc_write_cond & zero)) & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: scoreboard bench for multicycle_control.
// Driver pushes per-cycle expectations; monitor pops and compares.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  Operation;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_en;
  logic [1:0]  pc_source;
  logic        reg_write;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        illegal_op;
  logic [3:0]  state;
  logic [31:0] retired;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .Operation(Operation),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source),
    .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [1:0]  op;
    logic        asa;
    logic [1:0]  asb;
    logic        iord;
    logic        mr;
    logic        mw;
    logic        irw;
    logic        pcen;
    logic [1:0]  pcs;
    logic        rw;
    logic        rd;
    logic        m2r;
    logic        ill;
    logic [31:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          ncyc = 0;
  logic [31:0] model_ret = 32'd0;

  function automatic bit legal(input logic [5:0] o);
    return o inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd12, 6'd2};
  endfunction

  // Expected controls for one cycle spent in step st of an instruction.
  function automatic exp_t model(input int st, input logic [5:0] iop,
                                 input logic mr, input logic z,
                                 input logic rst);
    exp_t e;
    e = '0;
    e.st = st[3:0];
    e.ret = model_ret;
    case (st)
      0: begin e.mr = 1; e.asb = 2'b01; e.irw = mr; e.pcen = mr; end
      1: begin e.asb = 2'b11; e.ill = !legal(iop); end
      2: begin e.asa = 1; e.asb = 2'b10; end
      3: begin e.mr = 1; e.iord = 1; end
      4: begin e.rw = 1; e.m2r = 1; end
      5: begin e.mw = 1; e.iord = 1; end
      6: begin e.asa = 1; e.op = 2'b10; end
      7: begin e.rw = 1; e.rd = 1; end
      8: begin e.asa = 1; e.op = 2'b01; e.pcen = z; e.pcs = 2'b01; end
      9: begin
        e.asa = 1; e.asb = 2'b10;
        e.op = (iop == 6'd12) ? 2'b11 : 2'b00;
      end
      10: e.rw = 1;
      11: begin e.pcen = 1; e.pcs = 2'b10; end
      default: ;
    endcase
    if (rst) begin
      e.mr = 0; e.mw = 0; e.irw = 0; e.pcen = 0; e.rw = 0; e.ill = 0;
    end
    return e;
  endfunction

  task automatic cyc(input int st, input logic [5:0] opin,
                     input logic [5:0] iop, input logic mr,
                     input logic rst);
    logic z;
    z = 1'($urandom_range(0, 1));
    opcode = opin;
    mem_ready = mr;
    zero = z;
    reset = rst;
    sb.push_back(model(st, iop, mr, z, rst));
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_z(input int st, input logic [5:0] opin,
                       input logic [5:0] iop, input logic z);
    opcode = opin;
    mem_ready = 1'($urandom_range(0, 1));
    zero = z;
    reset = 1'b0;
    sb.push_back(model(st, iop, mem_ready, z, 1'b0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction: fetch stalls, decode, then the opcode's path.
  task automatic run(input logic [5:0] op, input int fst, input int mst,
                     input bit rst_mw, input int bz);
    logic [5:0] g;
    for (int i = 0; i < fst; i++) cyc(0, op, op, 1'b0, 1'b0);
    cyc(0, op, op, 1'b1, 1'b0);
    cyc(1, op, op, rb(), 1'b0);
    g = 6'($urandom);
    case (op)
      6'd0: begin cyc(6, g, op, rb(), 0); cyc(7, g, op, rb(), 0); end
      6'd35: begin
        cyc(2, g, op, rb(), 0);
        for (int i = 0; i < mst; i++) cyc(3, g, op, 1'b0, 0);
        cyc(3, g, op, 1'b1, 0);
        cyc(4, g, op, rb(), 0);
      end
      6'd43: begin
        cyc(2, g, op, rb(), 0);
        if (rst_mw) begin
          cyc(5, g, op, 1'b1, 1'b1);
          model_ret = 32'd0;
          return;
        end
        for (int i = 0; i < mst; i++) cyc(5, g, op, 1'b0, 0);
        cyc(5, g, op, 1'b1, 0);
      end
      6'd4: begin
        if (bz < 0) cyc(8, g, op, rb(), 0);
        else cyc_z(8, g, op, 1'(bz));
      end
      6'd8, 6'd12: begin cyc(9, g, op, rb(), 0); cyc(10, g, op, rb(), 0); end
      6'd2: cyc(11, g, op, rb(), 0);
      default: return;
    endcase
    model_ret = model_ret + 32'd1;
  endtask

  // Monitor: compare every presented cycle against the scoreboard head.
  always @(negedge clk) begin
    exp_t a, e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = '{state, Operation, alu_src_a, alu_src_b, iord, mem_read,
            mem_write, ir_write, pc_en, pc_source, reg_write, reg_dst,
            mem_to_reg, illegal_op, retired};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cyc%0d st=%0d: got %h want %h",
                 ncyc, e.st, a, e);
      end
      ncyc++;
    end
  end

  logic [5:0] ops [7];
  initial begin
    ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd12, 6'd2};
    reset = 1'b1;
    opcode = 6'd0;
    zero = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc(0, 6'd0, 6'd0, 1'b1, 1'b1);
    run(6'd0, 0, 0, 0, -1);
    run(6'd35, 0, 2, 0, -1);
    run(6'd4, 0, 0, 0, 1);
    run(6'd4, 1, 0, 0, 0);
    run(6'd12, 0, 0, 0, -1);
    run(6'd8, 0, 0, 0, -1);
    run(6'b111111, 0, 0, 0, -1);
    run(6'd43, 1, 1, 0, -1);
    run(6'd2, 0, 0, 0, -1);
    run(6'd43, 0, 0, 1, -1);
    run(6'd0, 0, 0, 0, -1);
    force dut.retired = 32'hFFFFFFFF;
    #1;
    release dut.retired;
    model_ret = 32'hFFFFFFFF;
    run(6'd8, 0, 0, 0, -1);
    run(6'd2, 0, 0, 0, -1);
    for (int n = 0; n < 120; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      run(op, $urandom_range(0, 2), $urandom_range(0, 2),
          ($urandom_range(0, 9) == 0), -1);
    end
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
